// File: rtl/xcorr_peak.sv
// Scans the correlator result RAM once per start and reports the largest value,
// its address and the corresponding signed lag.
module xcorr_peak #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] peak_val_o,
    output logic [ADDR_W-1:0] peak_addr_o,
    output logic [ADDR_W-1:0] lag_o
);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] LagFlip  = {1'b1, {(ADDR_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] tag_q;
    logic [ADDR_W-1:0] tag_addr_q [RD_LAT];
    logic [DATA_W-1:0] max_q, max_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] peak_val_q, peak_val_d;
    logic [ADDR_W-1:0] peak_addr_q, peak_addr_d;
    logic [ADDR_W-1:0] lag_q, lag_d;
    logic              issue;
    logic              scan_entry;
    logic              sample_vld;
    logic              last_sample;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        scan_entry  = 1'b0;
        issue       = (state_q == StScan);
        sample_vld  = tag_q[RD_LAT-1];
        last_sample = sample_vld && (tag_addr_q[RD_LAT-1] == LastAddr);

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StScan;
                    addr_d     = '0;
                    scan_entry = 1'b1;
                end
            end
            StScan: begin
                if (addr_q == LastAddr) begin
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: begin
                if (last_sample) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Running max; strict compare keeps the lowest address on ties.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (scan_entry) begin
            max_d = '0;
            idx_d = '0;
        end else if (sample_vld && (rd_data_i > max_q)) begin
            max_d = rd_data_i;
            idx_d = tag_addr_q[RD_LAT-1];
        end
    end

    // Results load from the next-state max so the final sample is included.
    always_comb begin
        peak_val_d  = peak_val_q;
        peak_addr_d = peak_addr_q;
        lag_d       = lag_q;
        if ((state_q == StDrain) && last_sample) begin
            peak_val_d  = max_d;
            peak_addr_d = idx_d;
            lag_d       = idx_d ^ LagFlip;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            tag_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            peak_val_q  <= '0;
            peak_addr_q <= '0;
            lag_q       <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_addr_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            max_q         <= max_d;
            idx_q         <= idx_d;
            peak_val_q    <= peak_val_d;
            peak_addr_q   <= peak_addr_d;
            lag_q         <= lag_d;
            tag_q[0]      <= issue;
            tag_addr_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i]      <= tag_q[i-1];
                tag_addr_q[i] <= tag_addr_q[i-1];
            end
        end
    end

    assign rd_addr_o   = addr_q;
    assign busy_o      = (state_q == StScan) || (state_q == StDrain);
    assign done_o      = (state_q == StDone);
    assign peak_val_o  = peak_val_q;
    assign peak_addr_o = peak_addr_q;
    assign lag_o       = lag_q;

endmodule

// File: tb/tb_xcorr_peak.sv
// Scoreboard bench for xcorr_peak: RAM model, reference max search, directed
// corner cases from the block description plus randomized RAM contents.
module tb_xcorr_peak;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int RL       = 2;
    localparam int N        = 1 << AW;
    localparam int DONE_LAT = N + RL + 1;

    typedef struct packed {
        logic [DW-1:0] val;
        logic [AW-1:0] addr;
        logic [AW-1:0] lag;
        logic [31:0]   cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] peak_val;
    logic [AW-1:0] peak_addr;
    logic [AW-1:0] lag;

    logic [DW-1:0] mem  [N];
    logic [DW-1:0] pipe [RL];
    exp_t          sb[$];
    exp_t          last_exp;
    int unsigned   errors = 0;
    int unsigned   checks = 0;
    int unsigned   cyc = 0;

    xcorr_peak #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
        .busy_o     (busy),
        .done_o     (done),
        .peak_val_o (peak_val),
        .peak_addr_o(peak_addr),
        .lag_o      (lag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with RL cycles from address register to q.
    always @(posedge clk) begin
        pipe[0] <= mem[rd_addr];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RL-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int unsigned cs);
        exp_t e;
        logic [DW-1:0] best = '0;
        logic [AW-1:0] at = '0;
        for (int a = 0; a < N; a++) begin
            if (mem[a] > best) begin
                best = mem[a];
                at   = AW'(a);
            end
        end
        e.val  = best;
        e.addr = at;
        e.lag  = at - AW'(N / 2);
        e.cyc  = cs + DONE_LAT;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done seen at cycle %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("peak_val", peak_val, e.val);
                chk("peak_addr", peak_addr, e.addr);
                chk("lag", lag, e.lag);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic fill(input logic [DW-1:0] v);
        for (int a = 0; a < N; a++) mem[a] = v;
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_peak_val", peak_val, 0);
        chk("rst_peak_addr", peak_addr, 0);
        chk("rst_lag", lag, 0);
    endtask

    // Start a scan now; optionally inject ignored starts; abort at abort_at if non-zero.
    task automatic run_scan(input bit extra, input int abort_at);
        exp_t e;
        int unsigned cs = cyc;
        e = model(cs);
        start = 1'b1;
        sb.push_back(e);
        tick();
        start = 1'b0;
        for (int r = 1; r <= DONE_LAT + 20 && sb.size() != 0; r++) begin
            if (r == 1) chk("busy_first", busy, 1);
            if (r == DONE_LAT - 1) chk("busy_last", busy, 1);
            if (r == 100) begin
                chk("held_peak_val", peak_val, last_exp.val);
                chk("held_lag", lag, last_exp.lag);
                chk("scan_rd_addr", rd_addr, 99);
            end
            if (abort_at != 0 && r == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                sb.delete();
                last_exp = '0;
                tick();
                tick();
                rst_n = 1'b1;
                return;
            end
            if (extra && (r == 5 || r == DONE_LAT - 1)) start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within bound, got none expected cycle %0d", e.cyc);
            sb.delete();
        end
        chk("rd_addr_hold", rd_addr, N - 1);
        last_exp = e;
    endtask

    task automatic chk_result(input string tag_s, input logic [DW-1:0] v,
                              input logic [AW-1:0] a, input logic [AW-1:0] l);
        chk({tag_s, "_val"}, peak_val, v);
        chk({tag_s, "_addr"}, peak_addr, a);
        chk({tag_s, "_lag"}, lag, l);
    endtask

    initial begin
        last_exp = '0;
        fill(8'h00);
        tick();
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        tick();

        fill(8'h00); mem[8'h80] = 8'h7F;
        run_scan(1'b0, 0);
        chk_result("spike", 8'h7F, 8'h80, 8'h00);

        fill(8'h05); mem[8'h10] = 8'hC8; mem[8'hF0] = 8'hC8;
        run_scan(1'b0, 0);
        chk_result("tie", 8'hC8, 8'h10, 8'h90);

        fill(8'h00);
        run_scan(1'b0, 0);
        chk_result("zero", 8'h00, 8'h00, 8'h80);

        fill(8'h00); mem[8'hFF] = 8'h01;
        run_scan(1'b0, 0);
        chk_result("top", 8'h01, 8'hFF, 8'h7F);

        fill(8'h00); mem[8'h20] = 8'hFF; mem[8'h21] = 8'h80;
        run_scan(1'b0, 0);
        chk_result("unsigned", 8'hFF, 8'h20, 8'hA0);

        // Ignored starts during the scan, then an immediate back-to-back run.
        fill(8'h00); mem[8'h80] = 8'h7F;
        run_scan(1'b1, 0);
        chk_result("busy_start", 8'h7F, 8'h80, 8'h00);
        mem[8'h33] = 8'h90;
        run_scan(1'b0, 0);
        chk_result("b2b", 8'h90, 8'h33, 8'hB3);

        // Abort mid-scan; no done may follow, then a clean restart.
        fill(8'h00); mem[8'h80] = 8'h7F;
        run_scan(1'b0, 100);
        for (int i = 0; i < DONE_LAT + 10; i++) tick();
        check_reset_outputs();
        run_scan(1'b0, 0);
        chk_result("restart", 8'h7F, 8'h80, 8'h00);

        for (int t = 0; t < 8; t++) begin
            int unsigned mode = $urandom_range(0, 2);
            for (int a = 0; a < N; a++) begin
                case (mode)
                    0:       mem[a] = DW'($urandom);
                    1:       mem[a] = DW'($urandom_range(0, 3));
                    default: mem[a] = ($urandom_range(0, 15) == 0) ? DW'($urandom) : '0;
                endcase
            end
            run_scan(1'b0, 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
